// File: rtl/hex_sr_pkg.sv
// Shared types, defaults and width helper for the hex_sr random-access controller.
package hex_sr_pkg;

  localparam int DEF_LENGTH = 40;
  localparam int DEF_WIDTH  = 6;

  typedef enum logic [1:0] {IDLE, WAIT, DONE, CLEAR} state_t;

  function automatic int slot_aw(input int len);
    return (len > 2) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/hex_sr_slot_ctr.sv
// Free-running modulo-LENGTH slot counter; pos names the digit at the hex_sr
// output this cycle, frame marks slot 0.
module hex_sr_slot_ctr
  import hex_sr_pkg::*;
#(
  parameter int LENGTH = DEF_LENGTH
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [slot_aw(LENGTH)-1:0] pos,
  output logic                       frame
);

  localparam int AW = slot_aw(LENGTH);
  localparam logic [AW-1:0] LAST = AW'(LENGTH - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      pos   <= '0;
      frame <= 1'b1;
    end else begin
      pos   <= (pos == LAST) ? '0 : pos + AW'(1);
      frame <= (pos == LAST);
    end
  end

endmodule

// File: rtl/hex_sr_ctrl.sv
// Single-requester random-access controller for the recirculating hex_sr digit memory.
// Define DLM_CLEAR_EN to zero every slot with a one-rotation CLEAR pass after reset.
module hex_sr_ctrl
  import hex_sr_pkg::*;
#(
  parameter int LENGTH = DEF_LENGTH,
  parameter int WIDTH  = DEF_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req,
  input  logic                       we,
  input  logic [slot_aw(LENGTH)-1:0] addr,
  input  logic [WIDTH-1:0]           wdata,
  output logic                       ack,
  output logic                       err,
  output logic [WIDTH-1:0]           rdata,
  output logic                       sr_recirc,
  output logic [WIDTH-1:0]           sr_data,
  input  logic [WIDTH-1:0]           sr_q,
  output logic [slot_aw(LENGTH)-1:0] pos,
  output logic                       frame,
  output logic                       busy
);

  localparam int AW = slot_aw(LENGTH);
  localparam logic [AW:0]   LEN_X = (AW+1)'(LENGTH);
  localparam logic [AW-1:0] LAST  = AW'(LENGTH - 1);

`ifdef DLM_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t state;
  logic   hit;
  logic   out_of_range;

  hex_sr_slot_ctr #(.LENGTH(LENGTH)) u_slot_ctr (
    .clk   (clk),
    .reset (reset),
    .pos   (pos),
    .frame (frame)
  );

  assign hit          = (state == WAIT) && (pos == addr);
  assign out_of_range = ({1'b0, addr} >= LEN_X);
  assign busy         = (state != IDLE);

  // A high req seen in IDLE is always a fresh request: the cycle before was
  // idle with req low, the DONE cycle, reset or the end of CLEAR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET_STATE;
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (out_of_range) begin
              state <= DONE;
              ack   <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (pos == addr) begin
            state <= DONE;
            ack   <= 1'b1;
            if (!we) rdata <= sr_q;
          end
        end
        DONE:    state <= IDLE;
        CLEAR:   if (pos == LAST) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The slot under the hex_sr input is replaced only on a write hit or while clearing.
  always_comb begin
    sr_recirc = 1'b1;
    sr_data   = '0;
    if (state == CLEAR) begin
      sr_recirc = 1'b0;
    end else if (hit && we) begin
      sr_recirc = 1'b0;
      sr_data   = wdata;
    end
  end

endmodule
